// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, LSB first, one borrow flop
//
// Computes {borrow_out, diff} = in0 - in1 - borrow_in, one bit per clock.
// Optional feature macro: OVERFLOW_FLAG_EN (adds the signed overflow output).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   in0, in1, borrow_in   minuend, subtrahend, incoming borrow
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   diff, borrow_out      result modulo 2^WIDTH, final borrow
//   overflow              signed overflow flag (OVERFLOW_FLAG_EN only)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    // Counter is at least one bit wide so WIDTH=1 never needs a zero-width vector.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] in0_sr, in1_sr;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             a, b, d, bw_next;
    logic [WIDTH-1:0] diff_shifted;
    logic             accept, last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);

    // One full-subtractor cell working on the current LSBs.
    assign a       = in0_sr[0];
    assign b       = in1_sr[0];
    assign d       = a ^ b ^ bw;
    assign bw_next = (~a & b) | (~(a ^ b) & bw);

    // Result bits enter at the MSB end so the first (LSB) bit ends up at bit 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_shifted = d;
        end else begin : g_wn
            assign diff_shifted = {d, diff[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in0_sr     <= '0;
            in1_sr     <= '0;
            bw         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            overflow   <= 1'b0;
`endif
        end else if (accept) begin
            in0_sr <= in0;
            in1_sr <= in1;
            bw     <= borrow_in;
            cnt    <= '0;
        end else if (state == RUN) begin
            in0_sr <= in0_sr >> 1;
            in1_sr <= in1_sr >> 1;
            bw     <= bw_next;
            diff   <= diff_shifted;
            if (last) begin
                borrow_out <= bw_next;
`ifdef OVERFLOW_FLAG_EN
                // On the last cycle a/b are the operand sign bits and d is the result sign.
                overflow   <= (a != b) && (d != a);
`endif
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
